parking_sensor_frontend: RTL and testbench

Sensor front-end that drives the event side of the parking controller's sensor interface, which accepts one event per cycle.
- Synchronises and debounces the raw gate loop sensor and four per-slot exit buttons.
- Latches the resulting requests and issues them one at a time as single-cycle entry_sensor / exit_sensor+exit_location pulses.
- Consumes the controller's registered door_open / full_light responses, holds the gate for a fixed time and flags rejected requests.

---
 rtl/parking_sensor_frontend_pkg.sv | 30 +++
 rtl/parking_sensor_frontend_debounce.sv | 47 ++++
 rtl/parking_sensor_frontend.sv | 170 +++++++++++++++++
 tb/tb_parking_sensor_frontend.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_sensor_frontend_pkg.sv
// Shared types and constants for the parking sensor front-end:
// FSM encoding, slot geometry and the fixed-priority request selector.
package parking_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;
  localparam int ENTRY_BIT = 4;
  localparam int PEND_W    = NUM_SLOTS + 1;
  localparam int SEL_W     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Exits win over entry; among exits the lowest slot index wins.
  function automatic logic [SEL_W-1:0] select_request(input logic [PEND_W-1:0] pend);
    logic [SEL_W-1:0] sel;
    sel = SEL_W'(ENTRY_BIT);
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (pend[i]) begin
        sel = SEL_W'(i);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/parking_sensor_frontend_debounce.sv
// One input bit: 2-flop synchroniser, stability counter and a registered
// pulse marking each accepted 0->1 transition.
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic             rise_r;
  logic [CNT_W-1:0] cnt_r;
  logic             accept_s;

  assign accept_s = (sync2_r != level_r) && (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign rise     = rise_r;

  // Synchroniser, mismatch counter and accepted level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      rise_r  <= 1'b0;
      cnt_r   <= '0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      rise_r  <= accept_s && sync2_r;
      if (accept_s) begin
        level_r <= sync2_r;
        cnt_r   <= '0;
      end else if (sync2_r != level_r) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= '0;
      end
    end
  end

endmodule

// File: rtl/parking_sensor_frontend.sv
// Debounces the gate loop and exit buttons, latches requests and feeds them
// one at a time to the parking controller, handling its door/full responses.
module parking_sensor_frontend
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 4,
  parameter int GATE_HOLD_CYCLES = 8,
  parameter int FULL_HOLD_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 raw_entry,
  input  logic [NUM_SLOTS-1:0] raw_exit,
  input  logic                 door_open,
  input  logic                 full_light,
  output logic                 entry_sensor,
  output logic                 exit_sensor,
  output logic [SLOT_W-1:0]    exit_location,
  output logic                 gate_active,
  output logic                 full_flash,
  output logic                 reject_pulse,
  output logic [PEND_W-1:0]    pending,
  output logic                 busy
);

  localparam int GATE_W = $clog2(GATE_HOLD_CYCLES + 1);
  localparam int FULL_W = $clog2(FULL_HOLD_CYCLES + 1);

  logic [PEND_W-1:0] raw_s;
  logic [PEND_W-1:0] rise_s;
  logic [PEND_W-1:0] clear_s;
  logic [PEND_W-1:0] pending_r;
  logic [SEL_W-1:0]  sel_s;
  logic [SEL_W-1:0]  sel_r;
  logic [GATE_W-1:0] gate_cnt_r;
  logic [FULL_W-1:0] full_cnt_r;
  logic [SLOT_W-1:0] loc_r;
  logic              entry_r;
  logic              exit_r;
  logic              gate_r;
  logic              busy_r;
  logic              last_entry_r;
  logic              issue_s;
  logic              full_resp_s;
  logic              reject_s;
  state_t            state_r;
  state_t            next_s;

  assign raw_s = {raw_entry, raw_exit};

  for (genvar i = 0; i < PEND_W; i++) begin : g_db
    sensor_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .raw  (raw_s[i]),
      .rise (rise_s[i])
    );
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next state; the RESP decision reacts to the controller in the same cycle.
  always_comb begin
    next_s      = state_r;
    issue_s     = 1'b0;
    full_resp_s = 1'b0;
    reject_s    = 1'b0;
    sel_s       = select_request(pending_r);
    case (state_r)
      IDLE: begin
        if (pending_r != '0) begin
          next_s  = ISSUE;
          issue_s = 1'b1;
        end else begin
          next_s = IDLE;
        end
      end
      ISSUE: begin
        next_s = RESP;
      end
      RESP: begin
        if (door_open) begin
          next_s = HOLD;
        end else if (full_light && last_entry_r) begin
          next_s      = IDLE;
          full_resp_s = 1'b1;
        end else begin
          next_s   = IDLE;
          reject_s = 1'b1;
        end
      end
      HOLD: begin
        if (gate_cnt_r == '0) begin
          next_s = IDLE;
        end else begin
          next_s = HOLD;
        end
      end
      default: begin
        next_s = IDLE;
      end
    endcase
  end

  // The bit chosen at IDLE is remembered, since pending may gain bits meanwhile.
  always_comb begin
    clear_s = '0;
    if (state_r == ISSUE) begin
      clear_s = PEND_W'(1'b1) << sel_r;
    end else begin
      clear_s = '0;
    end
  end

  // Request latch (set beats clear), event pulses and hold counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_r    <= '0;
      sel_r        <= '0;
      entry_r      <= 1'b0;
      exit_r       <= 1'b0;
      loc_r        <= '0;
      gate_r       <= 1'b0;
      busy_r       <= 1'b0;
      last_entry_r <= 1'b0;
      gate_cnt_r   <= '0;
      full_cnt_r   <= '0;
    end else begin
      pending_r <= (pending_r & ~clear_s) | rise_s;
      if (issue_s) begin
        sel_r <= sel_s;
      end
      entry_r      <= issue_s && (sel_s == SEL_W'(ENTRY_BIT));
      exit_r       <= issue_s && (sel_s != SEL_W'(ENTRY_BIT));
      loc_r        <= (issue_s && (sel_s != SEL_W'(ENTRY_BIT))) ? sel_s[SLOT_W-1:0] : '0;
      gate_r       <= (next_s == HOLD);
      busy_r       <= (next_s != IDLE);
      last_entry_r <= entry_r;
      if ((state_r == RESP) && (next_s == HOLD)) begin
        gate_cnt_r <= GATE_W'(GATE_HOLD_CYCLES - 1);
      end else if (gate_cnt_r != '0) begin
        gate_cnt_r <= gate_cnt_r - GATE_W'(1);
      end
      if (full_resp_s) begin
        full_cnt_r <= FULL_W'(FULL_HOLD_CYCLES - 1);
      end else if (full_cnt_r != '0) begin
        full_cnt_r <= full_cnt_r - FULL_W'(1);
      end
    end
  end

  assign entry_sensor  = entry_r;
  assign exit_sensor   = exit_r;
  assign exit_location = loc_r;
  assign gate_active   = gate_r;
  assign busy          = busy_r;
  assign pending       = pending_r;
  assign reject_pulse  = reject_s;
  assign full_flash    = full_resp_s || (full_cnt_r != '0);

endmodule

// File: tb/tb_parking_sensor_frontend.sv
// Randomised scoreboard bench: a timestamp-based reference model predicts
// events, rejects and level outputs; a negedge monitor pops and compares.
module tb_parking_sensor_frontend;

  localparam int D    = 4;
  localparam int G    = 8;
  localparam int F    = 8;
  localparam int MAXC = 8000;
  localparam int BIG  = 1000000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       raw_entry = 1'b0;
  logic [3:0] raw_exit = 4'b0000;
  logic       door_open = 1'b0;
  logic       full_light = 1'b0;
  logic       entry_sensor, exit_sensor, gate_active, full_flash, reject_pulse, busy;
  logic [1:0] exit_location;
  logic [4:0] pending;

  parking_sensor_frontend #(
    .DEBOUNCE_CYCLES (D),
    .GATE_HOLD_CYCLES(G),
    .FULL_HOLD_CYCLES(F)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .raw_entry    (raw_entry),
    .raw_exit     (raw_exit),
    .door_open    (door_open),
    .full_light   (full_light),
    .entry_sensor (entry_sensor),
    .exit_sensor  (exit_sensor),
    .exit_location(exit_location),
    .gate_active  (gate_active),
    .full_flash   (full_flash),
    .reject_pulse (reject_pulse),
    .pending      (pending),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       is_entry;
    logic [1:0] loc;
  } ev_t;

  typedef struct {
    int         cyc;
    logic       busy;
    logic       gate;
    logic       flash;
    logic [4:0] pend;
  } lvl_t;

  ev_t  ev_q[$];
  int   rej_q[$];
  lvl_t lvl_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int resp_mode = 1;
  bit noise_en = 1'b0;
  logic prev_entry = 1'b0;
  logic prev_exit = 1'b0;

  logic [4:0] raw_hist [0:MAXC];
  logic       rst_hist [0:MAXC];

  logic [4:0] m_acc = '0, m_pend = '0, m_rise = '0, m_clear = '0;
  int m_idle_from = 0, m_issue_cyc = -10, m_issue_bit = 0;
  int m_gate_lo = 1, m_gate_hi = 0, m_full_until = -1, m_rlast = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model for cycle k: sync = raw two cycles earlier, a level is
  // accepted once the last D synced samples all disagree with it.
  task automatic model_step(input int k);
    logic [4:0] pend_prev;
    logic [4:0] new_rise;
    logic       s2;
    bit         all_diff;
    lvl_t       l;
    ev_t        e;
    if (rst_hist[k-1]) begin
      m_acc = '0; m_pend = '0; m_rise = '0; m_clear = '0;
      m_idle_from = k; m_issue_cyc = -10;
      m_gate_lo = 1; m_gate_hi = 0; m_full_until = -1; m_rlast = k - 1;
    end else begin
      pend_prev = m_pend;
      m_pend = (m_pend & ~m_clear) | m_rise;
      m_clear = '0;
      new_rise = '0;
      for (int b = 0; b < 5; b++) begin
        all_diff = 1'b1;
        for (int j = k - D; j < k; j++) begin
          s2 = (j - 2 > m_rlast) ? raw_hist[j-2][b] : 1'b0;
          if (s2 == m_acc[b]) all_diff = 1'b0;
        end
        if (all_diff) begin
          m_acc[b] = ~m_acc[b];
          new_rise[b] = m_acc[b];
        end
      end
      m_rise = new_rise;
      if (k == m_issue_cyc + 1) begin
        if (door_open) begin
          m_gate_lo = k + 1; m_gate_hi = k + G; m_idle_from = k + 1 + G;
        end else if (full_light && m_issue_bit == 4) begin
          m_full_until = k + F - 1; m_idle_from = k + 1;
        end else begin
          rej_q.push_back(k); m_idle_from = k + 1;
        end
      end else if (k - 1 >= m_idle_from && pend_prev != 5'b00000) begin
        m_issue_bit = 4;
        for (int i = 3; i >= 0; i--) if (pend_prev[i]) m_issue_bit = i;
        m_issue_cyc = k;
        m_idle_from = BIG;
        m_clear = 5'b00001 << m_issue_bit;
        e.cyc = k;
        e.is_entry = (m_issue_bit == 4);
        e.loc = (m_issue_bit == 4) ? 2'd0 : 2'(m_issue_bit);
        ev_q.push_back(e);
      end
    end
    l.cyc = k;
    l.busy = (k < m_idle_from);
    l.gate = (k >= m_gate_lo) && (k <= m_gate_hi);
    l.flash = (k <= m_full_until);
    l.pend = m_pend;
    lvl_q.push_back(l);
  endtask

  // One cycle: controller stub, model prediction, then new raw/reset levels.
  task automatic tick(input logic [4:0] raw_v, input logic rst_v);
    int r;
    @(posedge clk);
    cyc++;
    #1;
    if (prev_entry || prev_exit) begin
      case (resp_mode)
        0: r = $urandom_range(0, 2);
        1: r = 0;
        2: r = 1;
        3: r = 2;
        4: r = prev_entry ? 1 : 0;
        default: r = 2;
      endcase
      door_open = (r == 0);
      full_light = (r == 1);
    end else begin
      door_open = noise_en && ($urandom_range(0, 7) == 0);
      full_light = noise_en && ($urandom_range(0, 7) == 0);
    end
    model_step(cyc);
    raw_entry = raw_v[4];
    raw_exit = raw_v[3:0];
    reset = rst_v;
    raw_hist[cyc] = raw_v;
    rst_hist[cyc] = rst_v;
  endtask

  // Monitor: compare levels every cycle, pop events/rejects when the DUT shows them.
  always @(negedge clk) begin
    lvl_t l;
    ev_t  e;
    int   rc;
    if (cyc > 0) begin
      chk("level_queue_nonempty", (lvl_q.size() > 0), 1);
      if (lvl_q.size() > 0) begin
        l = lvl_q.pop_front();
        chk("busy", busy, l.busy);
        chk("gate_active", gate_active, l.gate);
        chk("full_flash", full_flash, l.flash);
        chk("pending", pending, l.pend);
      end
      if (entry_sensor === 1'b1 || exit_sensor === 1'b1) begin
        chk("event_expected", (ev_q.size() > 0), 1);
        if (ev_q.size() > 0) begin
          e = ev_q.pop_front();
          chk("event_cycle", cyc, e.cyc);
          chk("entry_sensor", entry_sensor, e.is_entry);
          chk("exit_sensor", exit_sensor, !e.is_entry);
          chk("exit_location", exit_location, e.loc);
        end
      end else begin
        if (ev_q.size() > 0 && ev_q[0].cyc <= cyc) begin
          e = ev_q.pop_front();
          chk("missing_event_at", cyc, e.cyc + BIG);
        end
        chk("exit_location_idle", exit_location, 2'd0);
      end
      if (reject_pulse === 1'b1) begin
        chk("reject_expected", (rej_q.size() > 0), 1);
        if (rej_q.size() > 0) begin
          rc = rej_q.pop_front();
          chk("reject_cycle", cyc, rc);
        end
      end else if (rej_q.size() > 0 && rej_q[0] <= cyc) begin
        rc = rej_q.pop_front();
        chk("missing_reject_at", cyc, rc + BIG);
      end
      prev_entry = (entry_sensor === 1'b1);
      prev_exit = (exit_sensor === 1'b1);
    end
  end

  initial begin
    int         hold [5];
    logic [4:0] lv;
    logic       rst;
    logic       e;
    raw_hist[0] = 5'b00000;
    rst_hist[0] = 1'b1;
    for (int b = 0; b < 5; b++) hold[b] = 0;
    lv = '0;

    repeat (3) tick(5'b00000, 1'b1);
    repeat (50) tick(5'b00000, 1'b0);

    // entry held, controller opens the door
    resp_mode = 1;
    repeat (30) tick(5'b10000, 1'b0);
    repeat (12) tick(5'b00000, 1'b0);

    // exits on slots 1 and 2 together
    repeat (40) tick(5'b00110, 1'b0);
    repeat (10) tick(5'b00000, 1'b0);

    // exit 0 holds the gate while two entry edges line up for back-to-back full
    resp_mode = 4;
    for (int i = 0; i < 45; i++) begin
      e = (i < 6) || (i >= 13 && i < 30);
      tick({e, 3'b000, (i < 30)}, 1'b0);
    end
    repeat (12) tick(5'b00000, 1'b0);

    // exit on slot 3, no response
    resp_mode = 3;
    repeat (20) tick(5'b01000, 1'b0);
    repeat (10) tick(5'b00000, 1'b0);

    // 3-cycle glitches on the gate loop
    resp_mode = 1;
    for (int i = 0; i < 5; i++) begin
      repeat (3) tick(5'b10000, 1'b0);
      repeat (4) tick(5'b00000, 1'b0);
    end
    repeat (10) tick(5'b00000, 1'b0);

    // reset lands in HOLD
    repeat (14) tick(5'b10000, 1'b0);
    tick(5'b00000, 1'b1);
    repeat (20) tick(5'b00000, 1'b0);

    // randomised traffic, responses, noise and occasional resets
    resp_mode = 0;
    noise_en = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 5; b++) begin
        if (hold[b] == 0) begin
          lv[b] = (b == 4) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
          hold[b] = $urandom_range(1, 16);
        end
        hold[b]--;
      end
      rst = ($urandom_range(0, 499) == 0);
      tick(lv, rst);
    end

    resp_mode = 1;
    noise_en = 1'b0;
    repeat (60) tick(5'b00000, 1'b0);
    @(negedge clk);
    #1;
    chk("events_drained", ev_q.size(), 0);
    chk("rejects_drained", rej_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
